// File: rtl/sequential_alu_arbiter.sv
// sequential_alu_arbiter
//   Round-robin scheduler sharing one sequential ALU between NUM_REQ
//   requesters. A requester is granted in IDLE, its operands and opcode are
//   captured, the matching ALU strobe is held through ISSUE until the ALU
//   accepts, and the result is returned with a one-cycle done pulse in DONE.
//
// Optional feature macro: SEQUENTIAL_ALU_ARBITER_TIMEOUT_EN
//   When defined, an ISSUE-cycle watchdog forces completion after
//   TIMEOUT_CYCLES cycles without accept (o_q=0, o_ovf=1, o_timeout=1).
//
// Ports:
//   i_clk, i_rst         clock (rising edge), synchronous active-high reset
//   i_req[NUM_REQ]       per-requester request level
//   i_op[2*NUM_REQ]      per-requester opcode (0 add, 1 sub, 2 mul, 3 div)
//   i_a, i_b             per-requester operands, DATA_WIDTH bits each
//   o_done[NUM_REQ]      one-hot result pulse
//   o_q, o_ovf           result and overflow, valid while o_done != 0
//   o_busy               high whenever the arbiter is not idle
//   o_alu_a, o_alu_b     operands to the shared ALU
//   o_alu_add/sub/mul/div  one-hot ALU operation strobes
//   i_alu_q, i_alu_ovf, i_alu_accept  ALU result interface
//   o_timeout            watchdog completion flag (macro builds only)

module sequential_alu_arbiter #(
  parameter int DATA_WIDTH     = 4,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [2*NUM_REQ-1:0]          i_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] i_a,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] i_b,
  output logic [NUM_REQ-1:0]            o_done,
  output logic [DATA_WIDTH-1:0]         o_q,
  output logic                          o_ovf,
  output logic                          o_busy,
  output logic [DATA_WIDTH-1:0]         o_alu_a,
  output logic [DATA_WIDTH-1:0]         o_alu_b,
  output logic                          o_alu_add,
  output logic                          o_alu_sub,
  output logic                          o_alu_mul,
  output logic                          o_alu_div,
  input  logic [DATA_WIDTH-1:0]         i_alu_q,
  input  logic                          i_alu_ovf,
  input  logic                          i_alu_accept
`ifdef SEQUENTIAL_ALU_ARBITER_TIMEOUT_EN
  ,
  output logic                          o_timeout
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Parameter sanity checks at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("sequential_alu_arbiter: NUM_REQ must be in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sequential_alu_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        grant_q, grant_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [DATA_WIDTH-1:0]   q_q, q_d;
  logic                    ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [3:0]              strobe_q, strobe_d;

  logic                    pick_valid;
  logic [PTR_W-1:0]        pick_idx;
  logic [PTR_W:0]          cand;
  logic [1:0]              pick_op;

`ifdef SEQUENTIAL_ALU_ARBITER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    timeout_q, timeout_d;
`endif

  // Round-robin pick: scan offsets from the highest down so that the
  // smallest offset from ptr (the first requester at or after ptr) wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(off);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (i_req[cand[PTR_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
    pick_op = i_op[int'(pick_idx)*2 +: 2];
  end

  // Next-state and next-output logic for the IDLE/ISSUE/DONE sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    done_d   = '0;
    q_d      = q_q;
    ovf_d    = ovf_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    strobe_d = strobe_q;
`ifdef SEQUENTIAL_ALU_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_idx;
          alu_a_d  = i_a[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          alu_b_d  = i_b[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          strobe_d = 4'b0001 << pick_op;
          ptr_d    = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d  = ISSUE;
`ifdef SEQUENTIAL_ALU_ARBITER_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ISSUE: begin
        // Accept takes priority over a watchdog expiry in the same cycle.
        if (i_alu_accept) begin
          q_d      = i_alu_q;
          ovf_d    = i_alu_ovf;
          done_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
          strobe_d = '0;
          state_d  = DONE;
        end
`ifdef SEQUENTIAL_ALU_ARBITER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          q_d       = '0;
          ovf_d     = 1'b1;
          done_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
          strobe_d  = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        // Strobes are already low here, giving the ALU a gap between ops.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      q_q      <= '0;
      ovf_q    <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      strobe_q <= '0;
`ifdef SEQUENTIAL_ALU_ARBITER_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      q_q      <= q_d;
      ovf_q    <= ovf_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      strobe_q <= strobe_d;
`ifdef SEQUENTIAL_ALU_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_done    = done_q;
  assign o_q       = q_q;
  assign o_ovf     = ovf_q;
  assign o_busy    = (state_q != IDLE);
  assign o_alu_a   = alu_a_q;
  assign o_alu_b   = alu_b_q;
  assign o_alu_add = strobe_q[0];
  assign o_alu_sub = strobe_q[1];
  assign o_alu_mul = strobe_q[2];
  assign o_alu_div = strobe_q[3];
`ifdef SEQUENTIAL_ALU_ARBITER_TIMEOUT_EN
  assign o_timeout = timeout_q;
`endif

endmodule
